display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 70 +++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-segment scanner with frame-synchronous double-buffered digit loads.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module display_scan_ctrl #(
  parameter int N = 4,
  parameter int DIV = 50000
) (
  input  logic           iClk,
  input  logic           iRst,
  input  logic [4*N-1:0] iDigits,
  input  logic           iLoad,
  input  logic           iEnable,
  output logic [3:0]     oDigit,
  output logic [N-1:0]   oAn,
  output logic           oLoadAck,
  output logic           oFrameDone
);
  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(N);
  logic [PW-1:0]  presc;
  logic [IW-1:0]  idx;
  logic [4*N-1:0] active, pending;
  logic           pendFlag;
  logic [N-1:0]   anStage;
  logic           tick, wrap, show;
  assign tick = iEnable && presc == PW'(DIV - 1);
  assign wrap = tick && idx == IW'(N - 1);
`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] hi;
  always_comb begin
    hi = '0;
    for (int i = 1; i < N; i++) hi = active[4*i +: 4] != 4'h0 ? IW'(i) : hi;
  end
  assign show = idx <= hi;
`else
  assign show = 1'b1;
`endif
  always_ff @(posedge iClk) begin
    if (iRst) begin
      presc      <= '0;
      idx        <= '0;
      active     <= '0;
      pending    <= '0;
      pendFlag   <= 1'b0;
      oDigit     <= 4'h0;
      anStage    <= '1;
      oAn        <= '1;
      oLoadAck   <= 1'b0;
      oFrameDone <= 1'b0;
    end else begin
      if (iEnable) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) idx <= wrap ? '0 : idx + 1'b1;
      end
      // a load arriving on the wrapping tick bypasses the pending buffer
      if (wrap) begin
        if (iLoad) active <= iDigits;
        else if (pendFlag) active <= pending;
        pendFlag <= 1'b0;
      end else if (iLoad) begin
        pending  <= iDigits;
        pendFlag <= 1'b1;
      end
      oLoadAck   <= wrap && (iLoad || pendFlag);
      oFrameDone <= wrap;
      oDigit     <= active[{idx, 2'b00} +: 4];
      anStage    <= ~({{(N-1){1'b0}}, iEnable & show} << idx);
      oAn        <= anStage;
    end
  end
endmodule
